// File: rtl/fb_fetch_queue_if.sv
// Fetch queue bus: PC/ROM capture side, PC hold request and decode handshake.
// The queue itself uses the slave modport.
interface fb_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_address;
  logic [ADDR_W-1:0] rom_data;
  logic              fetch_valid;
  logic              flush;
  logic              pc_write;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_instr;
  logic [CW-1:0]     fq_count;

  modport master (
    output pc_address,
    output rom_data,
    output fetch_valid,
    output flush,
    output id_ready,
    input  pc_write,
    input  id_valid,
    input  id_pc,
    input  id_instr,
    input  fq_count
  );

  modport slave (
    input  pc_address,
    input  rom_data,
    input  fetch_valid,
    input  flush,
    input  id_ready,
    output pc_write,
    output id_valid,
    output id_pc,
    output id_instr,
    output fq_count
  );
endinterface

// File: rtl/fb_fetch_queue.sv
// Instruction fetch queue between the PC register and decode.
// Buffers {PC, ROM word} pairs; holds the PC when full, empties on flush.
module fb_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              fq_reset,
  fb_fetch_queue_if.slave   fq
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;

  logic empty;
  logic full;
  logic push;
  logic pop;
  entry_t head;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign pop  = ~empty & fq.id_ready & ~fq.flush;
  assign push = fq.fetch_valid & ~fq.flush & (~full | pop);

  assign fq.pc_write = fq.fetch_valid & ~fq.flush & full & ~pop;

  assign head        = mem[rd_ptr];
  assign fq.id_valid = ~empty;
  assign fq.id_pc    = empty ? '0 : head.pc;
  assign fq.id_instr = empty ? '0 : head.instr;
  assign fq.fq_count = count;

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: fq.pc_address, instr: fq.rom_data};
    end
  end

  always_ff @(posedge clk or posedge fq_reset) begin
    if (fq_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fq.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_fetch_queue.sv
// Directed and random checks of fb_fetch_queue against a queue-based model.
module tb_fb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic clk;
  logic fq_reset;

  fb_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  fb_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .fq_reset (fq_reset),
    .fq       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  logic [63:0] q [$];
  logic [31:0] pc;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pcw_e);
    logic [63:0] hd;
    hd = (q.size() > 0) ? q[0] : 64'd0;
    chk({tag, ".id_valid"}, 64'(bus.id_valid), 64'(q.size() > 0));
    chk({tag, ".id_pc"},    64'(bus.id_pc),    64'(hd[63:32]));
    chk({tag, ".id_instr"}, 64'(bus.id_instr), 64'(hd[31:0]));
    chk({tag, ".fq_count"}, 64'(bus.fq_count), 64'(q.size()));
    chk({tag, ".pc_write"}, 64'(bus.pc_write), 64'(pcw_e));
  endtask

  // One clock: drive, check mid-cycle, step model after the edge.
  task automatic cyc(input string tag, input logic fv, input logic fl,
                     input logic rdy, input logic [31:0] redir);
    logic pop_e, push_e, pcw_e;
    bus.fetch_valid = fv;
    bus.flush       = fl;
    bus.id_ready    = rdy;
    bus.pc_address  = pc;
    bus.rom_data    = rom(pc);
    #3;
    pop_e  = (q.size() > 0) && rdy && !fl;
    push_e = fv && !fl && ((q.size() < DEPTH) || pop_e);
    pcw_e  = fv && !fl && (q.size() == DEPTH) && !pop_e;
    chk_out(tag, pcw_e);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      pc = redir;
    end else begin
      if (pop_e) void'(q.pop_front());
      if (push_e) q.push_back({pc, rom(pc)});
      if (fv && !pcw_e) pc = pc + 1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pc = 0;
    fq_reset = 1'b1;
    bus.fetch_valid = 1'b0;
    bus.flush = 1'b0;
    bus.id_ready = 1'b0;
    bus.pc_address = '0;
    bus.rom_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0);
    @(negedge clk);
    fq_reset = 1'b0;

    // fill to full, then hold
    for (int i = 0; i < 5; i++) cyc("fill", 1, 0, 0, 0);
    chk("hold_pc", 64'(pc), 64'd4);
    chk("head_pc", 64'(bus.id_pc), 64'd0);
    chk("head_in", 64'(bus.id_instr), 64'(rom(0)));

    // streaming at full, pointers wrap
    for (int i = 0; i < 8; i++) cyc("stream", 1, 0, 1, 0);

    // drain, then single push at pc 8
    for (int i = 0; i < 5; i++) cyc("drain", 0, 0, 1, 0);
    pc = 8;
    cyc("push8", 1, 0, 0, 0);
    chk("pc8_vis", 64'(bus.id_pc), 64'd8);
    cyc("see8", 0, 0, 1, 0);
    cyc("empty8", 0, 0, 0, 0);

    // flush with three queued
    for (int i = 0; i < 3; i++) cyc("pre_fl", 1, 0, 0, 0);
    cyc("flush", 1, 1, 1, 32'h20);
    cyc("redir", 1, 0, 0, 0);
    chk("redir_pc", 64'(bus.id_pc), 64'h20);
    cyc("redir2", 0, 0, 0, 0);

    // async reset between edges
    for (int i = 0; i < 2; i++) cyc("pre_rst", 1, 0, 0, 0);
    fq_reset = 1'b1;
    #1;
    chk("rst.count", 64'(bus.fq_count), 64'd0);
    chk("rst.valid", 64'(bus.id_valid), 64'd0);
    chk("rst.pc",    64'(bus.id_pc),    64'd0);
    q.delete();
    pc = 32'h40;
    @(negedge clk);
    fq_reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc("post_rst", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("post_drn", 0, 0, 1, 0);

    // fetch_valid toggling
    for (int i = 0; i < 6; i++) cyc("toggle", i[0] == 1'b0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom % 4) != 0, ($urandom % 16) == 0,
          ($urandom % 3) != 0, $urandom & 32'hFFFF_FFF0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
